// File: rtl/sipo_rx_if.sv
// rtl/sipo_rx_if.sv - serial line in, parallel word and status out for sipo_rx
interface sipo_rx_if #(parameter int WIDTH = 4);
  logic             serial_input;
  logic [WIDTH-1:0] parallel_output;
  logic             valid;
  logic             parity_error;
  logic             frame_error;
  logic             busy;

  modport master (
    output serial_input,
    input  parallel_output, valid, parity_error, frame_error, busy
  );

  modport slave (
    input  serial_input,
    output parallel_output, valid, parity_error, frame_error, busy
  );
endinterface

// File: rtl/sipo_rx.sv
// rtl/sipo_rx.sv - framed serial receiver: start, WIDTH data bits LSB-first, even parity, stop=0
module sipo_rx #(
  parameter int WIDTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  sipo_rx_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] shreg;
  logic             par_bit;
  logic [WIDTH-1:0] pout;
  logic             valid_r;
  logic             perr_r;
  logic             ferr_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      count   <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      pout    <= '0;
      valid_r <= 1'b0;
      perr_r  <= 1'b0;
      ferr_r  <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.serial_input) begin
            state <= DATA;
            count <= '0;
          end
        end
        DATA: begin
          for (int i = 0; i < WIDTH; i++) begin
            if (count == CW'(i)) shreg[i] <= bus.serial_input;
          end
          count <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) state <= PARITY;
        end
        PARITY: begin
          par_bit <= bus.serial_input;
          state   <= STOP;
        end
        STOP: begin
          // Errored frames are still delivered; flags tell downstream what went wrong.
          pout    <= shreg;
          perr_r  <= (^shreg) ^ par_bit;
          ferr_r  <= bus.serial_input;
          valid_r <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.parallel_output = pout;
  assign bus.valid           = valid_r;
  assign bus.parity_error    = perr_r;
  assign bus.frame_error     = ferr_r;
  assign bus.busy            = (state != IDLE);
endmodule

// File: tb/tb_sipo_rx.sv
// tb/tb_sipo_rx.sv - scoreboard bench for sipo_rx with WIDTH=4
module tb_sipo_rx;
  localparam int W = 4;

  logic clk;
  logic rst;
  int   cyc;
  int   nvec;
  int   nerr;

  typedef struct {
    logic [W-1:0] d;
    logic         pe;
    logic         fe;
    int           cyc;
  } exp_t;

  exp_t sb[$];

  sipo_rx_if #(.WIDTH(W)) bus ();
  sipo_rx #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Start bit is driven before edge E0 (cyc+1); valid is seen after E(W+2).
  task automatic send(input logic [W-1:0] d, input logic p, input logic s);
    exp_t e;
    @(negedge clk);
    bus.serial_input = 1'b1;
    e.d   = d;
    e.pe  = (^d) ^ p;
    e.fe  = s;
    e.cyc = cyc + 1 + W + 2;
    sb.push_back(e);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      bus.serial_input = d[i];
    end
    @(negedge clk);
    bus.serial_input = p;
    @(negedge clk);
    bus.serial_input = s;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.serial_input = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (rst && bus.valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'(bus.valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("data", 32'(bus.parallel_output), 32'(e.d));
        check("parity_error", 32'(bus.parity_error), 32'(e.pe));
        check("frame_error", 32'(bus.frame_error), 32'(e.fe));
        check("valid_cycle", 32'(cyc), 32'(e.cyc));
        check("busy_in_valid", 32'(bus.busy), 32'd0);
      end
    end
  end

  initial begin
    nvec = 0;
    nerr = 0;
    rst = 1'b0;
    bus.serial_input = 1'b0;
    #1;
    check("rst_data", 32'(bus.parallel_output), 32'd0);
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_flags", 32'({bus.parity_error, bus.frame_error}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Idle line right after reset
    idle(20);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_flags", 32'({bus.parity_error, bus.frame_error}), 32'd0);

    send(4'hD, 1'b1, 1'b0);
    idle(3);
    send(4'hD, 1'b0, 1'b0);
    idle(3);
    send(4'h0, 1'b0, 1'b0);
    idle(3);
    send(4'h6, 1'b0, 1'b1);
    idle(4);
    check("after_bad_stop_busy", 32'(bus.busy), 32'd0);

    send(4'h3, 1'b0, 1'b0);
    send(4'hA, 1'b0, 1'b0);
    idle(3);
    check("b2b_last_data", 32'(bus.parallel_output), 32'hA);

    // Reset mid-frame after the second data bit
    @(negedge clk); bus.serial_input = 1'b1;
    @(negedge clk); bus.serial_input = 1'b1;
    @(negedge clk); bus.serial_input = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_data", 32'(bus.parallel_output), 32'd0);
    check("midrst_valid", 32'(bus.valid), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_flags", 32'({bus.parity_error, bus.frame_error}), 32'd0);
    @(negedge clk);
    bus.serial_input = 1'b0;
    rst = 1'b1;
    idle(10);
    check("post_rst_busy", 32'(bus.busy), 32'd0);
    send(4'h9, 1'b0, 1'b0);
    idle(20);
    check("final_busy", 32'(bus.busy), 32'd0);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
